// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Takes one parallel word over a valid/ready handshake and shifts it out on
//   uart_tx as a UART frame. The frame is a start bit, then the data LSB first,
//   then an optional parity bit, then one or two stop bits. A baud counter
//   running on uart_clk sets the bit timing.
//
//   Handshake contract: a word transfers on any uart_clk edge where
//   tx_valid && tx_ready. tx_ready is high only while idle. tx_data is
//   captured on that edge, and tx_valid/tx_data are ignored at all other times.
//
//   All outputs are registered. They are computed from the next-state values,
//   so each output changes on the same edge as the state that owns it.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 uart_clk,
  input  logic                 uart_reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;

  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD_SENSE  = (PARITY_ODD != 0);
  localparam logic             HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic tx_q, tx_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic baud_wrap;
  logic accept;
  logic parity_bit;

  // The last cycle of the current serial bit.
  assign baud_wrap = (baud_q == BAUD_LAST);

  // A transfer happens only while the registered ready is high, which means idle.
  assign accept = tx_valid && ready_q;

  // The parity covers the latched word. Odd sense inverts the even result.
  assign parity_bit = (^data_q) ^ ODD_SENSE;

  // Next-state logic: the frame sequencer, the baud counter and the bit index.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = tx_data;
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end

      ST_START: begin
        if (baud_wrap) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_PARITY: begin
        if (baud_wrap) begin
          state_d = ST_STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with it.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);

    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_d];
      ST_PARITY: tx_d = parity_bit;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  // State, counter and data registers. Reset abandons any frame in progress.
  always_ff @(posedge uart_clk) begin
    if (uart_reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  // Output registers. Reset forces the line high and suppresses tx_done.
  always_ff @(posedge uart_clk) begin
    if (uart_reset) begin
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx  = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4.
// Four instances cover the frame formats: 8N1, 8E1, 8O1 and 8N2.
module tb_uart_tx_serializer;

  localparam int CPB = 4;

  logic       clk;
  logic       uart_reset;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_ready [4];
  logic       uart_tx  [4];
  logic       tx_busy  [4];
  logic       tx_done  [4];

  int checks   = 0;
  int failures = 0;

  // Mid-bit samples of the most recent frame, stored as cap[bit position].
  logic [11:0] cap;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .uart_clk(clk), .uart_reset(uart_reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .uart_tx(uart_tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .uart_clk(clk), .uart_reset(uart_reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .uart_tx(uart_tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .uart_clk(clk), .uart_reset(uart_reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .uart_tx(uart_tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .uart_clk(clk), .uart_reset(uart_reset), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
    .tx_ready(tx_ready[3]), .uart_tx(uart_tx[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

  // One comparison: counted, and reported on a mismatch.
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line level expected at frame bit position p (0 = start bit).
  function automatic logic exp_level(input logic [7:0] d, input int pe, input int po, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
    if (pe != 0 && p == 9) return (^d) ^ (po != 0);
    return 1'b1;
  endfunction

  // Checks the idle outputs of instance k at the current sample point.
  task automatic chk_idle(input string tag, input int k);
    chk({tag, "_tx"},    12'(uart_tx[k]),  12'd1);
    chk({tag, "_ready"}, 12'(tx_ready[k]), 12'd1);
    chk({tag, "_busy"},  12'(tx_busy[k]),  12'd0);
    chk({tag, "_done"},  12'(tx_done[k]),  12'd0);
  endtask

  // driver: waits for a negedge and presents a word. The caller decides when valid drops.
  task automatic drive_word(input int k, input logic [7:0] d);
    @(negedge clk);
    chk("pre_ready", 12'(tx_ready[k]), 12'd1);
    tx_valid[k] = 1'b1;
    tx_data[k]  = d;
    @(posedge clk);
  endtask

  // Follows one frame, starting from the handshake edge. It checks every cycle
  // from 1 to N+1. When inject_c > 0, it pulses valid=1 with 0x3C during cycle
  // inject_c. When abort_c > 0, it asserts reset during cycle abort_c and stops there.
  task automatic expect_frame(input string tag, input int k, input logic [7:0] d,
                              input int pe, input int po, input int sb,
                              input int inject_c, input int abort_c);
    int n;
    n   = (1 + 8 + pe + sb) * CPB;
    cap = '1;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c <= n) begin
        chk({tag, "_tx"},   12'(uart_tx[k]),  12'(exp_level(d, pe, po, (c - 1) / CPB)));
        chk({tag, "_busy"}, 12'(tx_busy[k]),  12'd1);
        chk({tag, "_rdy"},  12'(tx_ready[k]), 12'd0);
        chk({tag, "_done"}, 12'(tx_done[k]),  12'd0);
        if ((c - 1) % CPB == 1) cap[(c - 1) / CPB] = uart_tx[k];
      end else begin
        chk({tag, "_end_tx"},   12'(uart_tx[k]),  12'd1);
        chk({tag, "_end_rdy"},  12'(tx_ready[k]), 12'd1);
        chk({tag, "_end_busy"}, 12'(tx_busy[k]),  12'd0);
        chk({tag, "_end_done"}, 12'(tx_done[k]),  12'd1);
      end
      if (inject_c != 0 && c == inject_c) begin
        tx_valid[k] = 1'b1;
        tx_data[k]  = 8'h3C;
      end
      if (inject_c != 0 && c == inject_c + 1) tx_valid[k] = 1'b0;
      if (abort_c != 0 && c == abort_c) begin
        uart_reset = 1'b1;
        @(negedge clk);
        chk_idle({tag, "_abort"}, k);
        uart_reset = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    uart_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tx_valid[k] = 1'b0;
      tx_data[k]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    // reset state of every instance
    for (int k = 0; k < 4; k++) chk_idle("reset", k);
    uart_reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("post_reset", 0);

    // 1: 0xA5 8N1, line 0,1,0,1,0,0,1,0,1,1 then done in cycle 41
    drive_word(0, 8'hA5);
    #1 tx_valid[0] = 1'b0;
    expect_frame("a5", 0, 8'hA5, 0, 0, 1, 0, 0);
    chk("a5_bits", 12'(cap[9:0]), 12'h34A);
    @(negedge clk);
    chk("a5_done_one_cycle", 12'(tx_done[0]), 12'd0);

    // 2a: even parity with 0x07 gives parity bit 1
    drive_word(1, 8'h07);
    #1 tx_valid[1] = 1'b0;
    expect_frame("e07", 1, 8'h07, 1, 0, 1, 0, 0);
    chk("e07_parity", 12'(cap[9]), 12'd1);
    chk("e07_bits", 12'(cap[10:0]), 12'h60E);

    // 2b: odd parity with 0x00 gives parity bit 1, frame of 44 cycles
    drive_word(2, 8'h00);
    #1 tx_valid[2] = 1'b0;
    expect_frame("o00", 2, 8'h00, 1, 1, 1, 0, 0);
    chk("o00_parity", 12'(cap[9]), 12'd1);

    // 3: two stop bits with 0xFF, low only during cycles 1..4, done in cycle 45
    drive_word(3, 8'hFF);
    #1 tx_valid[3] = 1'b0;
    expect_frame("ff2", 3, 8'hFF, 0, 0, 2, 0, 0);
    chk("ff2_bits", 12'(cap[10:0]), 12'h7FE);

    // 4: back-to-back 0x55 then 0xAA with valid held high
    drive_word(0, 8'h55);
    #1 tx_data[0] = 8'hAA;
    expect_frame("b55", 0, 8'h55, 0, 0, 1, 0, 0);
    chk("b55_bits", 12'(cap[9:0]), 12'h2AA);
    @(posedge clk);  // the second handshake, at the end of cycle 41
    #1 tx_valid[0] = 1'b0;
    expect_frame("baa", 0, 8'hAA, 0, 0, 1, 0, 0);
    chk("baa_bits", 12'(cap[9:0]), 12'h354);

    // 5: a valid pulse with 0x3C in cycle 10 is ignored
    drive_word(0, 8'h96);
    #1 tx_valid[0] = 1'b0;
    expect_frame("ign", 0, 8'h96, 0, 0, 1, 10, 0);
    chk("ign_bits", 12'(cap[9:0]), 12'h32C);
    @(negedge clk);
    chk_idle("ign_after", 0);

    // 6: reset in cycle 15 aborts the frame, then 0x81 goes out cleanly
    drive_word(0, 8'hC3);
    #1 tx_valid[0] = 1'b0;
    expect_frame("abt", 0, 8'hC3, 0, 0, 1, 0, 15);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_idle("abt_quiet", 0);
    end
    drive_word(0, 8'h81);
    #1 tx_valid[0] = 1'b0;
    expect_frame("r81", 0, 8'h81, 0, 0, 1, 0, 0);
    chk("r81_bits", 12'(cap[9:0]), 12'h302);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard cap on simulated time, so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
